// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor.
// One operand bit pair is processed per clock, LSB first, so an operation
// takes WIDTH cycles in ADD plus one DONE cycle that presents the result.
// Subtraction is a + ~b + 1: b is inverted at capture and the carry
// starts at 1.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit counter wide enough to index 0..WIDTH-1; it stops at LAST and
  // never wraps inside an operation.
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_bit;
  logic             w_carry_out;
  logic             w_last;

  // Full adder on the current LSBs of the shifting operand registers.
  assign w_bit       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_out = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last      = (r_count == LAST);

  // start is only honoured in IDLE, so requests while busy are dropped.
  assign w_accept    = (r_state == S_IDLE) && start;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the Moore outputs busy and done.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one bit per ADD cycle; the result
  // registers are left untouched in DONE and IDLE so they hold until the
  // next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_ADD) begin
      r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carry_out;
      if (w_last) begin
        // MSB cycle: r_carry is the carry into the MSB, w_carry_out the
        // carry out of it; their disagreement is signed overflow.
        r_cout <= w_carry_out;
        r_ovf  <= r_carry ^ w_carry_out;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 2..32.
REQ-002 The block SHALL provide port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL provide port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL provide port sub, input, 1 bit: operation select, 0 = a+b, 1 = a-b.
REQ-006 The block SHALL provide port a, input, WIDTH bits: first operand.
REQ-007 The block SHALL provide port b, input, WIDTH bits: second operand.
REQ-008 The block SHALL provide port busy, output, 1 bit: operation in progress (states ADD and DONE).
REQ-009 The block SHALL provide port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 The block SHALL provide port sum, output, WIDTH bits: result.
REQ-011 The block SHALL provide port cout, output, 1 bit: carry out; for subtraction, 1 = no borrow (a >= b unsigned).
REQ-012 The block SHALL provide port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-014 IDLE: start is sampled only in IDLE; start=1 moves the FSM to ADD.
- ADD: the FSM stays in ADD for exactly WIDTH cycles, then moves to DONE.
- DONE: the FSM moves to IDLE unconditionally after one cycle.
REQ-015 On the edge that accepts start, the block SHALL capture:
- a_reg <= a; b_reg <= (sub ? ~b : b); carry <= sub; count <= 0;
- sum, cout and ovf <= 0.
REQ-016 Each ADD cycle SHALL process one bit, LSB first:
- bit = a_reg[0] ^ b_reg[0] ^ carry;
- carry <= majority(a_reg[0], b_reg[0], carry);
- sum <= {bit, sum[WIDTH-1:1]};
- a_reg and b_reg shift right by 1; count increments.
REQ-017 On the final ADD cycle (count == WIDTH-1):
- cout SHALL take the carry out of the MSB;
- ovf SHALL take (carry into MSB) XOR (carry out of MSB).
REQ-018 done SHALL be high only in the DONE state, asserted exactly WIDTH+1 rising edges after the edge that accepted start, for one cycle.
REQ-019 busy SHALL be high in ADD and DONE and low in IDLE.
REQ-020 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 sum, cout and ovf SHALL hold their final values from DONE until the next accepted start.
REQ-022 Changes on a, b or sub after acceptance SHALL NOT affect the operation in progress.
REQ-023 count SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-024 start held high continuously SHALL start a new operation on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-025 rst=1 SHALL asynchronously force:
- state IDLE; busy=0; done=0;
- sum=0; cout=0; ovf=0; a_reg=0; b_reg=0; carry=0; count=0.
REQ-026 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, sub=0, a=0x5A, b=0x3C -> done 9 edges after accept, sum=0x96, cout=0, ovf=1.
REQ-028 WIDTH=8, sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0; also a=0x20, b=0x10 -> sum=0x10, cout=1.
REQ-029 WIDTH=8, sub=0, a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
REQ-030 WIDTH=16, sub=0, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1, done 17 edges after accept.
REQ-031 start pulsed in ADD with different operands -> ignored; original result delivered, then busy=0.
REQ-032 rst pulsed at the 4th ADD cycle -> all outputs 0, no done; next start with 0x01+0x01 -> sum=0x02.
